tc_event_monitor: RTL and testbench
===================================

Name: tc_event_monitor

Overview:
- Sits directly downstream of the cascaded counter chain on the DE10-Lite top level and consumes the chain's final terminal-count output.
- Detects each terminal-count rising edge and counts the events.
- Measures the clock-cycle period between consecutive events, tracking last, min and max.
- Flags stalls and multiplexes the statistics onto LEDR[9:0] via a 2-bit select.

Parameters:
- CNT_W, 16, event counter width (saturating).
- PER_W, 32, period counter and period register width.
- TIMEOUT, 100000000, cycles without an event before entering STALL (2 s at 50 MHz).

Ports:
- clk  input  1  system clock (MAX10_CLK1_50).
- reset  input  1  asynchronous, active-high.
- tc_in  input  1  terminal count from last counter of the chain, synchronous to clk, may be a pulse or a level.
- clear  input  1  synchronous statistics clear, active-high.
- sel  input  2  LED display select.
- event_count  output  CNT_W  number of tc rising edges since reset/clear.
- last_period  output  PER_W  cycles between the two most recent edges.
- min_period  output  PER_W  smallest measured period.
- max_period  output  PER_W  largest measured period.
- seen  output  1  sticky, set on the first edge.
- stall  output  1  high while in STALL.
- state  output  2  IDLE=00, RUN=01, STALL=10.
- led  output  10  display word.

Behaviour:
- Reset (async): tc_q=0, state=IDLE, cyc=0, event_count=0, last_period=0, min_period=all-ones, max_period=0, seen=0, stall=0.
- Edge detect: tc_rise = tc_in & ~tc_q; tc_q registered every cycle.
  - Statistics update on the clock edge where tc_rise is high, so latency is 1 cycle after tc_in rises.
  - A level held high counts once.
- cyc counts cycles since the last edge.
  - On tc_rise, cyc<=1.
  - Otherwise, in RUN/STALL, cyc<=cyc+1, saturating at all-ones.
  - cyc is held 0 in IDLE.
  - For edges at clock edges t0 and t1, the captured period is t1-t0.
- IDLE:
  - On tc_rise: go to RUN, seen<=1, event_count<=1, cyc<=1.
  - No period is captured on the first edge.
- RUN:
  - On tc_rise: last_period<=cyc; min_period<=min(min_period,cyc); max_period<=max(max_period,cyc); event_count+1, saturating at all-ones; cyc<=1.
  - Else, if cyc==TIMEOUT-1 (cycle TIMEOUT is counted this cycle): go to STALL, stall<=1.
- STALL:
  - cyc keeps counting, saturating.
  - On tc_rise: same updates as RUN using the current cyc, then go to RUN and set stall<=0.
- tc_rise arriving in the same cycle as the timeout condition: the event wins, stay in RUN.
- clear:
  - Highest synchronous priority; a coincident tc_rise is discarded.
  - Returns all statistics, seen, stall and state to their reset values.
  - tc_q keeps updating, so a tc level already high at clear does not retrigger.
- min_period reads all-ones until two edges have occurred.
- led (combinational from registers):
  - sel=00: {seen, stall, event_count[7:0]}
  - sel=01: last_period[PER_W-1 -: 10]
  - sel=10: min_period[PER_W-1 -: 10]
  - sel=11: max_period[PER_W-1 -: 10]
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for a clock edge.
- After reset deassertion, the first tc_rise is treated as the first event.

Test Plan:
1. Reset, then single tc_in pulse at cycle 5 -> next cycle: seen=1, event_count=1, state=RUN, last_period=0, min_period=all-ones.
2. Pulses at cycles 10, 20, 27 -> after the third: event_count=3, last_period=7, min_period=7, max_period=10.
3. tc_in held high for 6 cycles -> event_count increments by exactly 1. Then low 3 cycles and high again -> last_period=9, event_count +1.
4. TIMEOUT=20, pulse then silence -> stall=1 and state=STALL exactly 20 cycles after the pulse edge. Pulse at 30 cycles -> last_period=30, max_period=30, stall=0, state=RUN.
5. clear asserted in the same cycle as a tc rising edge, tc held high -> all stats at reset values, state=IDLE, no event counted. tc low then high -> event_count=1.
6. CNT_W=4, 20 pulses -> event_count saturates at 15. Async reset mid-RUN between clock edges -> outputs zeroed immediately. sel sweep 00..11 -> led matches the defined slices.

Source files
------------

// File: rtl/tc_event_monitor.sv
// ---------------------------------------------------------------------------
// tc_event_monitor
//
// Watches the terminal-count output of the cascaded counter chain. It counts
// rising edges of that signal, measures the clock-cycle period between
// consecutive edges (last / min / max), flags a stall when no edge arrives
// for TIMEOUT cycles, and shows one statistic on ten LEDs.
//
// Parameters:
//   CNT_W   - event counter width; the counter saturates at all-ones
//   PER_W   - period counter and period register width (must be >= 10)
//   TIMEOUT - cycles without an edge before the monitor enters STALL
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   tc_in       in   terminal count, synchronous to clk, pulse or level
//   clear       in   synchronous statistics clear, active-high
//   sel[1:0]    in   LED display select
//   event_count out  rising edges seen since reset/clear
//   last_period out  cycles between the two most recent edges
//   min_period  out  smallest measured period (all-ones until two edges)
//   max_period  out  largest measured period
//   seen        out  sticky flag, set by the first edge
//   stall       out  high while in STALL
//   state[1:0]  out  IDLE=00, RUN=01, STALL=10
//   led[9:0]    out  display word picked by sel
// ---------------------------------------------------------------------------
module tc_event_monitor #(
   parameter int CNT_W   = 16,
   parameter int PER_W   = 32,
   parameter int TIMEOUT = 100000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tc_in,
   input  logic             clear,
   input  logic [1:0]       sel,
   output logic [CNT_W-1:0] event_count,
   output logic [PER_W-1:0] last_period,
   output logic [PER_W-1:0] min_period,
   output logic [PER_W-1:0] max_period,
   output logic             seen,
   output logic             stall,
   output logic [1:0]       state,
   output logic [9:0]       led
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10
   } state_t;

   // The stall decision is taken one cycle early, on the cycle whose count
   // brings cyc to TIMEOUT, so stall rises together with that count.
   localparam logic [PER_W-1:0] CYC_LIMIT = PER_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic               tc_q, tc_d;
   logic [PER_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   event_count_q, event_count_d;
   logic [PER_W-1:0]   last_period_q, last_period_d;
   logic [PER_W-1:0]   min_period_q, min_period_d;
   logic [PER_W-1:0]   max_period_q, max_period_d;
   logic               seen_q, seen_d;
   logic               stall_q, stall_d;
   logic               tc_rise;
   logic [7:0]         count_low;

   // A held-high level produces exactly one rise because tc_q follows tc_in
   // every cycle, including cycles where clear is active.
   assign tc_rise = tc_in & ~tc_q;

   // Next-state and statistics update. clear wins over everything and drops
   // any coincident edge. The first edge after IDLE only starts the period
   // timer; later edges capture cyc, which at that moment equals the number
   // of clock edges since the previous event.
   always_comb begin
      tc_d          = tc_in;
      state_d       = state_q;
      cyc_d         = cyc_q;
      event_count_d = event_count_q;
      last_period_d = last_period_q;
      min_period_d  = min_period_q;
      max_period_d  = max_period_q;
      seen_d        = seen_q;
      stall_d       = stall_q;

      if (clear) begin
         state_d       = ST_IDLE;
         cyc_d         = '0;
         event_count_d = '0;
         last_period_d = '0;
         min_period_d  = '1;
         max_period_d  = '0;
         seen_d        = 1'b0;
         stall_d       = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cyc_d = '0;
               if (tc_rise) begin
                  state_d       = ST_RUN;
                  seen_d        = 1'b1;
                  event_count_d = CNT_W'(1);
                  cyc_d         = PER_W'(1);
               end
            end
            ST_RUN, ST_STALL: begin
               if (tc_rise) begin
                  last_period_d = cyc_q;
                  if (cyc_q < min_period_q) begin
                     min_period_d = cyc_q;
                  end
                  if (cyc_q > max_period_q) begin
                     max_period_d = cyc_q;
                  end
                  if (event_count_q != '1) begin
                     event_count_d = event_count_q + CNT_W'(1);
                  end
                  cyc_d   = PER_W'(1);
                  state_d = ST_RUN;
                  stall_d = 1'b0;
               end else begin
                  if (cyc_q != '1) begin
                     cyc_d = cyc_q + PER_W'(1);
                  end
                  if ((state_q == ST_RUN) && (cyc_q == CYC_LIMIT)) begin
                     state_d = ST_STALL;
                     stall_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cyc_d   = '0;
               stall_d = 1'b0;
            end
         endcase
      end
   end

   // State and statistics registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tc_q          <= 1'b0;
         state_q       <= ST_IDLE;
         cyc_q         <= '0;
         event_count_q <= '0;
         last_period_q <= '0;
         min_period_q  <= '1;
         max_period_q  <= '0;
         seen_q        <= 1'b0;
         stall_q       <= 1'b0;
      end else begin
         tc_q          <= tc_d;
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         event_count_q <= event_count_d;
         last_period_q <= last_period_d;
         min_period_q  <= min_period_d;
         max_period_q  <= max_period_d;
         seen_q        <= seen_d;
         stall_q       <= stall_d;
      end
   end

   // The LED word always shows eight count bits; narrow counters are
   // zero-extended so small CNT_W builds still display correctly.
   generate
      if (CNT_W >= 8) begin : g_count_wide
         assign count_low = event_count_q[7:0];
      end else begin : g_count_narrow
         assign count_low = {{(8 - CNT_W){1'b0}}, event_count_q};
      end
   endgenerate

   // Display multiplexer: status and low count bits, or the top ten bits of
   // one of the period registers.
   always_comb begin
      led = {seen_q, stall_q, count_low};
      case (sel)
         2'b01:   led = last_period_q[PER_W-1 -: 10];
         2'b10:   led = min_period_q[PER_W-1 -: 10];
         2'b11:   led = max_period_q[PER_W-1 -: 10];
         default: led = {seen_q, stall_q, count_low};
      endcase
   end

   assign event_count = event_count_q;
   assign last_period = last_period_q;
   assign min_period  = min_period_q;
   assign max_period  = max_period_q;
   assign seen        = seen_q;
   assign stall       = stall_q;
   assign state       = state_q;

endmodule

// File: tb/tb_tc_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_tc_event_monitor
//
// Drives two tc_event_monitor instances from the same stimulus: a wide one
// (CNT_W=16, PER_W=32) and a narrow one (CNT_W=4, PER_W=12) so that count
// saturation and non-trivial LED period slices are both visible. Both use
// TIMEOUT=20. Expected values come from an event-time model: it remembers
// the clock-edge index of the last event and derives periods, stall and
// state from edge-index differences.
// ---------------------------------------------------------------------------
module tb_tc_event_monitor;

   localparam int TB_TIMEOUT = 20;

   logic        clk;
   logic        reset;
   logic        tc_in;
   logic        clear;
   logic [1:0]  sel;

   logic [15:0] ec_a;
   logic [31:0] lp_a, mn_a, mx_a;
   logic        seen_a, stall_a;
   logic [1:0]  state_a;
   logic [9:0]  led_a;

   logic [3:0]  ec_b;
   logic [11:0] lp_b, mn_b, mx_b;
   logic        seen_b, stall_b;
   logic [1:0]  state_b;
   logic [9:0]  led_b;

   int n_cmp;
   int n_err;

   longint m_k;
   bit     m_prev_tc;
   bit     m_have;
   longint m_last_edge;
   longint m_cnt;
   longint m_last;
   longint m_min;
   longint m_max;

   tc_event_monitor #(.CNT_W(16), .PER_W(32), .TIMEOUT(TB_TIMEOUT)) dut_a (
      .clk(clk), .reset(reset), .tc_in(tc_in), .clear(clear), .sel(sel),
      .event_count(ec_a), .last_period(lp_a), .min_period(mn_a),
      .max_period(mx_a), .seen(seen_a), .stall(stall_a), .state(state_a),
      .led(led_a)
   );

   tc_event_monitor #(.CNT_W(4), .PER_W(12), .TIMEOUT(TB_TIMEOUT)) dut_b (
      .clk(clk), .reset(reset), .tc_in(tc_in), .clear(clear), .sel(sel),
      .event_count(ec_b), .last_period(lp_b), .min_period(mn_b),
      .max_period(mx_b), .seen(seen_b), .stall(stall_b), .state(state_b),
      .led(led_b)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint sat(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_reset();
      m_k         = 0;
      m_prev_tc   = 1'b0;
      m_have      = 1'b0;
      m_last_edge = 0;
      m_cnt       = 0;
      m_last      = 0;
      m_min       = -1;
      m_max       = 0;
   endtask

   // Advance the model by one clock edge using the inputs present now.
   task automatic model_update();
      bit     rise;
      longint p;
      m_k       = m_k + 1;
      rise      = tc_in && !m_prev_tc;
      m_prev_tc = tc_in;
      if (clear) begin
         m_have = 1'b0;
         m_cnt  = 0;
         m_last = 0;
         m_min  = -1;
         m_max  = 0;
      end else if (rise) begin
         if (m_have) begin
            p      = m_k - m_last_edge;
            m_last = p;
            if (m_min < 0 || p < m_min) m_min = p;
            if (p > m_max) m_max = p;
         end
         m_have      = 1'b1;
         m_cnt       = m_cnt + 1;
         m_last_edge = m_k;
      end
   endtask

   function automatic bit exp_stall();
      return m_have && ((m_k - m_last_edge + 1) >= TB_TIMEOUT);
   endfunction

   function automatic logic [127:0] snap_a_act();
      return {2'b00, ec_a, lp_a, mn_a, mx_a, seen_a, stall_a, state_a, led_a};
   endfunction

   function automatic logic [63:0] snap_b_act();
      return {10'd0, ec_b, lp_b, mn_b, mx_b, seen_b, stall_b, state_b, led_b};
   endfunction

   function automatic logic [127:0] snap_a_exp();
      logic [15:0] c;
      logic [31:0] l, mn, mx;
      logic        st;
      logic [1:0]  s;
      logic [9:0]  ld;
      c  = 16'(sat(m_cnt, 65535));
      l  = 32'(sat(m_last, 64'd4294967295));
      mn = (m_min < 0) ? 32'hFFFF_FFFF : 32'(sat(m_min, 64'd4294967295));
      mx = 32'(sat(m_max, 64'd4294967295));
      st = exp_stall();
      s  = m_have ? (st ? 2'b10 : 2'b01) : 2'b00;
      case (sel)
         2'b01:   ld = l[31:22];
         2'b10:   ld = mn[31:22];
         2'b11:   ld = mx[31:22];
         default: ld = {m_have, st, c[7:0]};
      endcase
      return {2'b00, c, l, mn, mx, m_have, st, s, ld};
   endfunction

   function automatic logic [63:0] snap_b_exp();
      logic [3:0]  c;
      logic [11:0] l, mn, mx;
      logic        st;
      logic [1:0]  s;
      logic [9:0]  ld;
      c  = 4'(sat(m_cnt, 15));
      l  = 12'(sat(m_last, 4095));
      mn = (m_min < 0) ? 12'hFFF : 12'(sat(m_min, 4095));
      mx = 12'(sat(m_max, 4095));
      st = exp_stall();
      s  = m_have ? (st ? 2'b10 : 2'b01) : 2'b00;
      case (sel)
         2'b01:   ld = l[11:2];
         2'b10:   ld = mn[11:2];
         2'b11:   ld = mx[11:2];
         default: ld = {m_have, st, 4'b0000, c};
      endcase
      return {10'd0, c, l, mn, mx, m_have, st, s, ld};
   endfunction

   // One clock: update the model for the coming edge, then wait for the
   // falling edge so outputs are sampled away from the active edge.
   task automatic tick();
      if (reset) model_reset();
      else model_update();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit tc, input bit clr);
      tc_in = tc;
      clear = clr;
   endtask

   task automatic pulse_gap(input int n);
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      repeat (n - 1) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      sel = 2'b00;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      sel = 2'b00;
      model_reset();
      tick();
      tick();
      n_cmp++;
      if (snap_a_act() !== snap_a_exp()) begin
         n_err++;
         $display("[TB] FAIL reset_snap_a: got %h want %h", snap_a_act(), snap_a_exp());
      end
      n_cmp++;
      if (snap_b_act() !== snap_b_exp()) begin
         n_err++;
         $display("[TB] FAIL reset_snap_b: got %h want %h", snap_b_act(), snap_b_exp());
      end
      n_cmp++;
      if (mn_a !== 32'hFFFF_FFFF || state_a !== 2'b00 || ec_a !== 16'd0) begin
         n_err++;
         $display("[TB] FAIL reset_values: got min=%h state=%b cnt=%0d want min=ffffffff state=00 cnt=0", mn_a, state_a, ec_a);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_pulse();
      do_reset();
      repeat (4) tick();
      applyStimulus(1'b1, 1'b0);
      n_cmp++;
      if (seen_a !== 1'b0 || ec_a !== 16'd0) begin
         n_err++;
         $display("[TB] FAIL single_before: got seen=%b cnt=%0d want seen=0 cnt=0", seen_a, ec_a);
      end
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (seen_a !== 1'b1 || ec_a !== 16'd1 || state_a !== 2'b01 ||
          lp_a !== 32'd0 || mn_a !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("[TB] FAIL single_after: got seen=%b cnt=%0d state=%b last=%0d min=%h want 1 1 01 0 ffffffff",
                  seen_a, ec_a, state_a, lp_a, mn_a);
      end
      n_cmp++;
      if (snap_b_act() !== snap_b_exp()) begin
         n_err++;
         $display("[TB] FAIL single_snap_b: got %h want %h", snap_b_act(), snap_b_exp());
      end
   endtask

   task automatic test_pulse_train();
      do_reset();
      repeat (9) tick();
      pulse_gap(10);
      pulse_gap(7);
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (ec_a !== 16'd3 || lp_a !== 32'd7 || mn_a !== 32'd7 || mx_a !== 32'd10) begin
         n_err++;
         $display("[TB] FAIL train_stats: got cnt=%0d last=%0d min=%0d max=%0d want 3 7 7 10", ec_a, lp_a, mn_a, mx_a);
      end
      n_cmp++;
      if (snap_a_act() !== snap_a_exp()) begin
         n_err++;
         $display("[TB] FAIL train_snap_a: got %h want %h", snap_a_act(), snap_a_exp());
      end
   endtask

   task automatic test_level_hold();
      do_reset();
      applyStimulus(1'b1, 1'b0);
      repeat (6) tick();
      n_cmp++;
      if (ec_a !== 16'd1) begin
         n_err++;
         $display("[TB] FAIL level_count: got %0d want 1", ec_a);
      end
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (lp_a !== 32'd9 || ec_a !== 16'd2) begin
         n_err++;
         $display("[TB] FAIL level_period: got last=%0d cnt=%0d want 9 2", lp_a, ec_a);
      end
      n_cmp++;
      if (snap_b_act() !== snap_b_exp()) begin
         n_err++;
         $display("[TB] FAIL level_snap_b: got %h want %h", snap_b_act(), snap_b_exp());
      end
   endtask

   task automatic test_stall();
      do_reset();
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      repeat (18) tick();
      n_cmp++;
      if (stall_a !== 1'b0 || state_a !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL stall_early: got stall=%b state=%b want 0 01", stall_a, state_a);
      end
      tick();
      n_cmp++;
      if (stall_a !== 1'b1 || state_a !== 2'b10) begin
         n_err++;
         $display("[TB] FAIL stall_enter: got stall=%b state=%b want 1 10", stall_a, state_a);
      end
      repeat (10) tick();
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (lp_a !== 32'd30 || mx_a !== 32'd30 || stall_a !== 1'b0 || state_a !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL stall_exit: got last=%0d max=%0d stall=%b state=%b want 30 30 0 01", lp_a, mx_a, stall_a, state_a);
      end
      repeat (18) tick();
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (lp_a !== 32'd19 || stall_a !== 1'b0 || state_a !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL stall_tie: got last=%0d stall=%b state=%b want 19 0 01", lp_a, stall_a, state_a);
      end
      n_cmp++;
      if (snap_a_act() !== snap_a_exp()) begin
         n_err++;
         $display("[TB] FAIL stall_snap_a: got %h want %h", snap_a_act(), snap_a_exp());
      end
   endtask

   task automatic test_clear();
      do_reset();
      pulse_gap(5);
      pulse_gap(5);
      applyStimulus(1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0);
      repeat (2) tick();
      n_cmp++;
      if (ec_a !== 16'd0 || seen_a !== 1'b0 || state_a !== 2'b00 ||
          mn_a !== 32'hFFFF_FFFF || lp_a !== 32'd0 || mx_a !== 32'd0) begin
         n_err++;
         $display("[TB] FAIL clear_stats: got cnt=%0d seen=%b state=%b min=%h last=%0d max=%0d want 0 0 00 ffffffff 0 0",
                  ec_a, seen_a, state_a, mn_a, lp_a, mx_a);
      end
      applyStimulus(1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (ec_a !== 16'd1 || state_a !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL clear_restart: got cnt=%0d state=%b want 1 01", ec_a, state_a);
      end
      n_cmp++;
      if (snap_b_act() !== snap_b_exp()) begin
         n_err++;
         $display("[TB] FAIL clear_snap_b: got %h want %h", snap_b_act(), snap_b_exp());
      end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (20) pulse_gap(3);
      n_cmp++;
      if (ec_b !== 4'd15 || ec_a !== 16'd20) begin
         n_err++;
         $display("[TB] FAIL sat_count: got b=%0d a=%0d want 15 20", ec_b, ec_a);
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (ec_a !== 16'd0 || seen_a !== 1'b0 || state_a !== 2'b00 ||
          mn_b !== 12'hFFF || lp_b !== 12'd0) begin
         n_err++;
         $display("[TB] FAIL async_reset: got cnt=%0d seen=%b state=%b minb=%h lastb=%0d want 0 0 00 fff 0",
                  ec_a, seen_a, state_a, mn_b, lp_b);
      end
      n_cmp++;
      if (snap_a_act() !== snap_a_exp()) begin
         n_err++;
         $display("[TB] FAIL async_snap_a: got %h want %h", snap_a_act(), snap_a_exp());
      end
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      n_cmp++;
      if (ec_a !== 16'd1 || lp_a !== 32'd0 || state_a !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL post_reset_first: got cnt=%0d last=%0d state=%b want 1 0 01", ec_a, lp_a, state_a);
      end
   endtask

   task automatic test_led_sweep();
      logic [9:0] want_b [4];
      want_b[0] = {1'b1, 1'b0, 8'd3};
      want_b[1] = 10'd4;
      want_b[2] = 10'd3;
      want_b[3] = 10'd4;
      do_reset();
      pulse_gap(13);
      pulse_gap(17);
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         n_cmp++;
         if (led_b !== want_b[s]) begin
            n_err++;
            $display("[TB] FAIL led_b_sel%0d: got %h want %h", s, led_b, want_b[s]);
         end
         n_cmp++;
         if (snap_a_act() !== snap_a_exp()) begin
            n_err++;
            $display("[TB] FAIL led_snap_a_sel%0d: got %h want %h", s, snap_a_act(), snap_a_exp());
         end
      end
      sel = 2'b00;
      @(negedge clk);
      model_update();
   endtask

   task automatic test_random();
      bit tc_now;
      do_reset();
      tc_now = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) tc_now = ~tc_now;
         applyStimulus(tc_now, ($urandom_range(0, 199) == 0));
         sel = 2'($urandom_range(0, 3));
         tick();
         n_cmp++;
         if (snap_a_act() !== snap_a_exp()) begin
            n_err++;
            $display("[TB] FAIL rand_snap_a@%0d: got %h want %h", i, snap_a_act(), snap_a_exp());
         end
         n_cmp++;
         if (snap_b_act() !== snap_b_exp()) begin
            n_err++;
            $display("[TB] FAIL rand_snap_b@%0d: got %h want %h", i, snap_b_act(), snap_b_exp());
         end
      end
      applyStimulus(1'b0, 1'b0);
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      tc_in = 1'b0;
      clear = 1'b0;
      sel   = 2'b00;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_pulse();
      test_pulse_train();
      test_level_hold();
      test_stall();
      test_clear();
      test_saturation();
      test_led_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
